// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - two-entry writeback buffer for ALU results with architectural C/Z flags
module alu_result_stage #(
    parameter int BITS = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [BITS:0] alu_out,
    input  logic          alu_carry,
    input  logic          alu_zero,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [BITS:0] out_data,
    output logic          out_carry,
    output logic          out_zero,
    output logic          flag_c,
    output logic          flag_z,
    output logic [7:0]    op_count,
    output logic          err_zero
);

    logic [1:0][BITS:0] data_q, data_d;
    logic [1:0]         c_q, c_d;
    logic [1:0]         z_q, z_d;
    logic               rd_q, rd_d;
    logic               wr_q, wr_d;
    logic [1:0]         count_q, count_d;
    logic               flag_c_q, flag_c_d;
    logic               flag_z_q, flag_z_d;
    logic [7:0]         op_count_q, op_count_d;
    logic               err_zero_q, err_zero_d;
    logic               push, pop;

    // in_ready looks only at registered occupancy, never at out_ready
    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = out_valid ? data_q[rd_q] : '0;
    assign out_carry = out_valid & c_q[rd_q];
    assign out_zero  = out_valid & z_q[rd_q];
    assign flag_c    = flag_c_q;
    assign flag_z    = flag_z_q;
    assign op_count  = op_count_q;
    assign err_zero  = err_zero_q;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_comb begin
        data_d     = data_q;
        c_d        = c_q;
        z_d        = z_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        count_d    = count_q;
        flag_c_d   = flag_c_q;
        flag_z_d   = flag_z_q;
        op_count_d = op_count_q;
        err_zero_d = err_zero_q;

        if (flush) begin
            // flush wins over any push/pop in the same cycle
            rd_d    = 1'b0;
            wr_d    = 1'b0;
            count_d = 2'd0;
        end else begin
            if (push) begin
                data_d[wr_q] = alu_out;
                c_d[wr_q]    = alu_carry;
                z_d[wr_q]    = alu_zero;
                wr_d         = ~wr_q;
                if (alu_zero != (alu_out == '0)) begin
                    err_zero_d = 1'b1;
                end
            end
            if (pop) begin
                rd_d       = ~rd_q;
                flag_c_d   = c_q[rd_q];
                flag_z_d   = z_q[rd_q];
                op_count_d = op_count_q + 8'd1;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q     <= '0;
            c_q        <= '0;
            z_q        <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            count_q    <= 2'd0;
            flag_c_q   <= 1'b0;
            flag_z_q   <= 1'b0;
            op_count_q <= 8'd0;
            err_zero_q <= 1'b0;
        end else begin
            data_q     <= data_d;
            c_q        <= c_d;
            z_q        <= z_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            count_q    <= count_d;
            flag_c_q   <= flag_c_d;
            flag_z_q   <= flag_z_d;
            op_count_q <= op_count_d;
            err_zero_q <= err_zero_d;
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - self-checking bench for alu_result_stage against a queue model
module tb_alu_result_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] alu_out;
    logic       alu_carry;
    logic       alu_zero;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] out_data;
    logic       out_carry;
    logic       out_zero;
    logic       flag_c;
    logic       flag_z;
    logic [7:0] op_count;
    logic       err_zero;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [8:0] d;
        logic       c;
        logic       z;
    } ent_t;

    ent_t mq[$];
    logic m_fc, m_fz, m_err;
    int   m_ops;

    alu_result_stage #(.BITS(8)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_carry(out_carry), .out_zero(out_zero),
        .flag_c(flag_c), .flag_z(flag_z), .op_count(op_count), .err_zero(err_zero)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        mq.delete();
        m_fc = 1'b0; m_fz = 1'b0; m_err = 1'b0; m_ops = 0;
    endfunction

    // Drive one cycle of inputs, advance the model, and return 1 ns after the edge
    task automatic step(input logic iv, input logic [8:0] d, input logic c, input logic z,
                        input logic ordy, input logic fl);
        ent_t e;
        bit   do_push, do_pop;
        in_valid = iv; alu_out = d; alu_carry = c; alu_zero = z;
        out_ready = ordy; flush = fl;
        if (fl) begin
            mq.delete();
        end else begin
            do_push = iv && (mq.size() < 2);
            do_pop  = ordy && (mq.size() > 0);
            if (do_push && (z != (d == 9'd0))) m_err = 1'b1;
            if (do_pop) begin
                e = mq.pop_front();
                m_fc = e.c; m_fz = e.z; m_ops = (m_ops + 1) % 256;
            end
            if (do_push) begin
                e.d = d; e.c = c; e.z = z;
                mq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        alu_out = '0; alu_carry = 1'b0; alu_zero = 1'b0;
        model_reset();
        #3;
        checks++;
        if ({in_ready, out_valid, out_data, out_carry, out_zero, flag_c, flag_z, op_count, err_zero} !== {1'b1, 1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: got rdy=%b v=%b d=%h c=%b z=%b fc=%b fz=%b ops=%0d err=%b, expected rdy=1 all others 0",
                     in_ready, out_valid, out_data, out_carry, out_zero, flag_c, flag_z, op_count, err_zero);
        end
        @(posedge clk); #1; rst_n = 1'b1;
        step(1, 9'h1FF, 1, 0, 0, 0);
        step(0, 9'h000, 0, 0, 1, 0);
        step(1, 9'h011, 1, 0, 0, 0);
        step(1, 9'h022, 1, 0, 0, 0);
        checks++;
        if ({out_valid, in_ready, flag_c} !== {1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_setup_full: got v=%b rdy=%b fc=%b, expected 1 0 1", out_valid, in_ready, flag_c);
        end
        rst_n = 1'b0;
        model_reset();
        #2;
        checks++;
        if ({out_valid, in_ready, flag_c, flag_z, op_count} !== {1'b1 ^ 1'b1, 1'b1, 1'b0, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL reset_async_midrun: got v=%b rdy=%b fc=%b fz=%b ops=%0d, expected v=0 rdy=1 fc=0 fz=0 ops=0",
                     out_valid, in_ready, flag_c, flag_z, op_count);
        end
        @(posedge clk); #1; rst_n = 1'b1;
    endtask

    task automatic test_single();
        step(1, 9'h03F, 0, 0, 1, 0);
        checks++;
        if ({out_valid, out_data} !== {1'b1, 9'h03F}) begin
            errors++;
            $display("FAIL single_latency: got v=%b d=%h, expected v=1 d=03f", out_valid, out_data);
        end
        step(0, 9'h000, 0, 0, 1, 0);
        checks++;
        if ({out_valid, flag_z, op_count} !== {1'b0, 1'b0, 8'd1}) begin
            errors++;
            $display("FAIL single_pop: got v=%b fz=%b ops=%0d, expected v=0 fz=0 ops=1", out_valid, flag_z, op_count);
        end
    endtask

    task automatic test_backpressure();
        step(1, 9'h000, 0, 1, 0, 0);
        step(1, 9'h100, 1, 0, 0, 0);
        checks++;
        if ({in_ready, out_valid, out_data} !== {1'b0, 1'b1, 9'h000}) begin
            errors++;
            $display("FAIL bp_full: got rdy=%b v=%b d=%h, expected rdy=0 v=1 d=000", in_ready, out_valid, out_data);
        end
        step(1, 9'h0AA, 0, 0, 0, 0);
        checks++;
        if ({in_ready, out_data, out_zero} !== {1'b0, 9'h000, 1'b1}) begin
            errors++;
            $display("FAIL bp_held: got rdy=%b d=%h z=%b, expected rdy=0 d=000 z=1", in_ready, out_data, out_zero);
        end
        step(0, 9'h000, 0, 0, 1, 0);
        checks++;
        if ({out_data, out_carry, flag_z, flag_c} !== {9'h100, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL bp_first_pop: got d=%h c=%b fz=%b fc=%b, expected d=100 c=1 fz=1 fc=0",
                     out_data, out_carry, flag_z, flag_c);
        end
        step(0, 9'h000, 0, 0, 1, 0);
        checks++;
        if ({out_valid, flag_c, flag_z, op_count} !== {1'b0, 1'b1, 1'b0, 8'(m_ops)}) begin
            errors++;
            $display("FAIL bp_second_pop: got v=%b fc=%b fz=%b ops=%0d, expected v=0 fc=1 fz=0 ops=%0d",
                     out_valid, flag_c, flag_z, op_count, m_ops);
        end
    endtask

    task automatic test_push_pop();
        int start;
        start = m_ops;
        step(1, 9'h001, 0, 0, 0, 0);
        for (int v = 2; v <= 10; v++) begin
            checks++;
            if (out_data !== 9'(v - 1)) begin
                errors++;
                $display("FAIL pp_order_%0d: got d=%h, expected %h", v, out_data, 9'(v - 1));
            end
            step(1, 9'(v), 0, 0, 1, 0);
            checks++;
            if ({out_valid, in_ready} !== 2'b11) begin
                errors++;
                $display("FAIL pp_count1_%0d: got v=%b rdy=%b, expected 1 1", v, out_valid, in_ready);
            end
        end
        checks++;
        if (out_data !== 9'h00A) begin
            errors++;
            $display("FAIL pp_last: got d=%h, expected 00a", out_data);
        end
        step(0, 9'h000, 0, 0, 1, 0);
        checks++;
        if ({out_valid, op_count} !== {1'b0, 8'((start + 10) % 256)}) begin
            errors++;
            $display("FAIL pp_opcount: got v=%b ops=%0d, expected v=0 ops=%0d", out_valid, op_count, (start + 10) % 256);
        end
    endtask

    task automatic test_zero_check();
        checks++;
        if (err_zero !== 1'b0) begin
            errors++;
            $display("FAIL zero_clean: got err=%b, expected 0", err_zero);
        end
        step(1, 9'h038, 0, 1, 0, 0);
        checks++;
        if (err_zero !== 1'b1) begin
            errors++;
            $display("FAIL zero_set: got err=%b, expected 1", err_zero);
        end
        step(0, 9'h000, 0, 0, 0, 1);
        checks++;
        if ({err_zero, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL zero_after_flush: got err=%b v=%b, expected err=1 v=0", err_zero, out_valid);
        end
        rst_n = 1'b0;
        model_reset();
        #2;
        checks++;
        if (err_zero !== 1'b0) begin
            errors++;
            $display("FAIL zero_reset: got err=%b, expected 0", err_zero);
        end
        @(posedge clk); #1; rst_n = 1'b1;
    endtask

    task automatic test_flush_wrap();
        step(1, 9'h055, 1, 0, 1, 0);
        step(0, 9'h000, 0, 0, 1, 0);
        step(1, 9'h066, 0, 0, 0, 0);
        step(1, 9'h077, 1, 0, 0, 0);
        step(1, 9'h088, 0, 0, 1, 1);
        checks++;
        if ({out_valid, in_ready, flag_c, flag_z, op_count} !== {1'b0, 1'b1, 1'b1, 1'b0, 8'd1}) begin
            errors++;
            $display("FAIL flush_state: got v=%b rdy=%b fc=%b fz=%b ops=%0d, expected v=0 rdy=1 fc=1 fz=0 ops=1",
                     out_valid, in_ready, flag_c, flag_z, op_count);
        end
        step(1, 9'h001, 0, 0, 1, 0);
        for (int i = 0; i < 255; i++) step(1, 9'h002, 0, 0, 1, 0);
        step(0, 9'h000, 0, 0, 1, 0);
        checks++;
        if ({out_valid, op_count} !== {1'b0, 8'd1}) begin
            errors++;
            $display("FAIL wrap_256: got v=%b ops=%0d, expected v=0 ops=1 (256 pops from 1)", out_valid, op_count);
        end
    endtask

    task automatic test_random();
        logic [8:0] d;
        logic       z;
        logic [8:0] e_d;
        logic       e_c, e_z;
        for (int i = 0; i < 500; i++) begin
            d = ($urandom_range(0, 3) == 0) ? 9'd0 : 9'($urandom);
            z = (d == 9'd0);
            if ($urandom_range(0, 40) == 0) z = ~z;
            step(1'($urandom), d, 1'($urandom), z, ($urandom_range(0, 2) != 0), ($urandom_range(0, 24) == 0));
            e_d = (mq.size() != 0) ? mq[0].d : 9'd0;
            e_c = (mq.size() != 0) ? mq[0].c : 1'b0;
            e_z = (mq.size() != 0) ? mq[0].z : 1'b0;
            checks++;
            if ({in_ready, out_valid, out_data, out_carry, out_zero, flag_c, flag_z, op_count, err_zero} !==
                {(mq.size() < 2), (mq.size() != 0), e_d, e_c, e_z, m_fc, m_fz, 8'(m_ops), m_err}) begin
                errors++;
                $display("FAIL random_%0d: got rdy=%b v=%b d=%h c=%b z=%b fc=%b fz=%b ops=%0d err=%b, expected rdy=%b v=%b d=%h c=%b z=%b fc=%b fz=%b ops=%0d err=%b",
                         i, in_ready, out_valid, out_data, out_carry, out_zero, flag_c, flag_z, op_count, err_zero,
                         (mq.size() < 2), (mq.size() != 0), e_d, e_c, e_z, m_fc, m_fz, m_ops, m_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_push_pop();
        test_zero_check();
        test_flush_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
